inst_queue: RTL and testbench

Instruction queue between the pre-IF/IF fetch stage and the ID stage. It holds up to `DEPTH` fetched (pc, instruction) pairs, so fetch can keep running while decode is stalled. It speaks the pipeline's valid / ready_go / allow_in handshake on both sides. It discards all contents on a pipeline flush (branch/jump redirect).

---
 rtl/inst_queue_if.sv | 32 +++
 rtl/inst_queue.sv | 62 ++++++
 tb/tb_inst_queue.sv | 159 +++++++++++++++
 3 files changed

// File: rtl/inst_queue_if.sv
// Handshake bundle between fetch, the instruction queue and decode.
// The slave modport is the queue's view; master is the surrounding pipeline.
interface inst_queue_if #(
  parameter int DEPTH      = 4,
  parameter int BUS_WIDTH  = 32,
  parameter int DATA_WIDTH = 32
);
  localparam int CNT_W = $clog2(DEPTH) + 1;

  logic                  flush;
  logic                  valid_if;
  logic                  ready_go_if;
  logic [BUS_WIDTH-1:0]  pc_if;
  logic [DATA_WIDTH-1:0] instruction_if;
  logic                  allow_in_iq;
  logic                  valid_iq;
  logic                  ready_go_iq;
  logic [BUS_WIDTH-1:0]  pc_iq;
  logic [DATA_WIDTH-1:0] instruction_iq;
  logic                  allow_in_id;
  logic [CNT_W-1:0]      count_iq;

  modport slave (
    input  flush, valid_if, ready_go_if, pc_if, instruction_if, allow_in_id,
    output allow_in_iq, valid_iq, ready_go_iq, pc_iq, instruction_iq, count_iq
  );

  modport master (
    output flush, valid_if, ready_go_if, pc_if, instruction_if, allow_in_id,
    input  allow_in_iq, valid_iq, ready_go_iq, pc_iq, instruction_iq, count_iq
  );
endinterface

// File: rtl/inst_queue.sv
// Circular-buffer instruction queue between fetch and decode; decouples a
// stalled ID stage from IF and drops everything on a redirect flush.
module inst_queue #(
  parameter int                    DEPTH      = 4,
  parameter int                    BUS_WIDTH  = 32,
  parameter int                    DATA_WIDTH = 32,
  parameter logic [DATA_WIDTH-1:0] NOP_INST   = DATA_WIDTH'(32'h00000013)
) (
  input logic          clk,
  input logic          rst,
  inst_queue_if.slave  iq
);
  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [BUS_WIDTH-1:0]  pc_mem   [DEPTH];
  logic [DATA_WIDTH-1:0] inst_mem [DEPTH];
  logic [PTR_W-1:0]      wr_ptr;
  logic [PTR_W-1:0]      rd_ptr;
  logic [CNT_W-1:0]      count;
  logic                  full;
  logic                  empty;
  logic                  push;
  logic                  pop;

  // Handshake decode is from registered occupancy only, so allow_in_iq has
  // no combinational dependency on allow_in_id.
  assign full  = (count == CNT_W'(DEPTH));
  assign empty = (count == '0);
  assign push  = iq.valid_if & iq.ready_go_if & ~full & ~iq.flush;
  assign pop   = ~empty & iq.allow_in_id & ~iq.flush;

  // Control state: pointers and occupancy
  always_ff @(posedge clk) begin
    if (rst || iq.flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      if (push && !pop)      count <= count + CNT_W'(1);
      else if (pop && !push) count <= count - CNT_W'(1);
    end
  end

  // Entry storage: data only, never cleared
  always_ff @(posedge clk) begin
    if (push) begin
      pc_mem[wr_ptr]   <= iq.pc_if;
      inst_mem[wr_ptr] <= iq.instruction_if;
    end
  end

  // Head presentation
  assign iq.allow_in_iq    = ~full;
  assign iq.valid_iq       = ~empty;
  assign iq.ready_go_iq    = ~empty;
  assign iq.pc_iq          = empty ? '0 : pc_mem[rd_ptr];
  assign iq.instruction_iq = empty ? NOP_INST : inst_mem[rd_ptr];
  assign iq.count_iq       = count;
endmodule

// File: tb/tb_inst_queue.sv
// Bench for inst_queue: directed scenarios plus randomized traffic, all
// checked against a queue-based reference model.
module tb_inst_queue;
  localparam int DEPTH = 4;
  localparam logic [31:0] NOP = 32'h00000013;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   errors = 0;

  logic [63:0] mq[$];
  bit          m_pushed;

  inst_queue_if #(.DEPTH(DEPTH), .BUS_WIDTH(32), .DATA_WIDTH(32)) iq ();

  inst_queue #(.DEPTH(DEPTH), .BUS_WIDTH(32), .DATA_WIDTH(32), .NOP_INST(NOP)) dut (
    .clk (clk),
    .rst (rst),
    .iq  (iq)
  );

  always #5 clk = ~clk;

  function automatic logic        m_valid(); return mq.size() != 0; endfunction
  function automatic logic        m_allow(); return mq.size() != DEPTH; endfunction
  function automatic logic [2:0]  m_count(); return 3'(mq.size()); endfunction
  function automatic logic [31:0] m_pc();    return (mq.size() != 0) ? mq[0][63:32] : 32'h0; endfunction
  function automatic logic [31:0] m_inst();  return (mq.size() != 0) ? mq[0][31:0] : NOP; endfunction

  // One clock: drive at negedge, advance model at posedge, settle 1 time unit.
  task automatic cyc(input logic r, input logic f, input logic v, input logic g,
                     input logic [31:0] pc, input logic [31:0] ins, input logic aid);
    bit mpush, mpop;
    @(negedge clk);
    rst = r; iq.flush = f; iq.valid_if = v; iq.ready_go_if = g;
    iq.pc_if = pc; iq.instruction_if = ins; iq.allow_in_id = aid;
    @(posedge clk);
    mpush = v && g && (mq.size() != DEPTH) && !f;
    mpop  = (mq.size() != 0) && aid && !f;
    m_pushed = 1'b0;
    if (r || f) mq.delete();
    else begin
      if (mpop)  void'(mq.pop_front());
      if (mpush) begin mq.push_back({pc, ins}); m_pushed = 1'b1; end
    end
    #1;
  endtask

  task automatic test_reset();
    cyc(1, 0, 0, 0, 0, 0, 0);
    cyc(1, 0, 1, 1, 32'h44, 32'h55, 1);
    checks++; if (iq.valid_iq !== 1'b0) begin errors++; $display("FAIL reset_valid got %b exp 0", iq.valid_iq); end
    checks++; if (iq.ready_go_iq !== 1'b0) begin errors++; $display("FAIL reset_ready_go got %b exp 0", iq.ready_go_iq); end
    checks++; if (iq.allow_in_iq !== 1'b1) begin errors++; $display("FAIL reset_allow got %b exp 1", iq.allow_in_iq); end
    checks++; if (iq.count_iq !== 3'd0) begin errors++; $display("FAIL reset_count got %0d exp 0", iq.count_iq); end
    checks++; if (iq.pc_iq !== 32'h0) begin errors++; $display("FAIL reset_pc got %h exp 0", iq.pc_iq); end
    checks++; if (iq.instruction_iq !== NOP) begin errors++; $display("FAIL reset_inst got %h exp %h", iq.instruction_iq, NOP); end
    cyc(0, 0, 1, 1, 32'h0, 32'h00500093, 0);
    checks++; if (iq.valid_iq !== 1'b1) begin errors++; $display("FAIL push1_valid got %b exp 1", iq.valid_iq); end
    checks++; if (iq.pc_iq !== 32'h0) begin errors++; $display("FAIL push1_pc got %h exp 0", iq.pc_iq); end
    checks++; if (iq.instruction_iq !== 32'h00500093) begin errors++; $display("FAIL push1_inst got %h exp 00500093", iq.instruction_iq); end
    checks++; if (iq.count_iq !== 3'd1) begin errors++; $display("FAIL push1_count got %0d exp 1", iq.count_iq); end
  endtask

  task automatic test_fill();
    cyc(1, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 4; i++) begin
      checks++; if (iq.allow_in_iq !== 1'b1) begin errors++; $display("FAIL fill_allow_pre%0d got %b exp 1", i, iq.allow_in_iq); end
      cyc(0, 0, 1, 1, 32'(i * 4), 32'h1000 + 32'(i), 0);
    end
    checks++; if (iq.allow_in_iq !== 1'b0) begin errors++; $display("FAIL fill_allow got %b exp 0", iq.allow_in_iq); end
    checks++; if (iq.count_iq !== 3'd4) begin errors++; $display("FAIL fill_count got %0d exp 4", iq.count_iq); end
    cyc(0, 0, 1, 1, 32'h10, 32'h1010, 0);
    checks++; if (iq.pc_iq !== 32'h0) begin errors++; $display("FAIL fill_head got %h exp 0", iq.pc_iq); end
    checks++; if (iq.count_iq !== 3'd4) begin errors++; $display("FAIL fill_5th_count got %0d exp 4", iq.count_iq); end
  endtask

  task automatic test_drain_wrap();
    logic [31:0] next_pc = 32'h10;
    int npop = 0;
    for (int i = 0; i < 12; i++) begin
      checks++; if (iq.valid_iq !== 1'b1) begin errors++; $display("FAIL drain_gap cyc%0d valid %b exp 1", i, iq.valid_iq); end
      checks++; if (iq.pc_iq !== 32'(npop * 4)) begin errors++; $display("FAIL drain_order cyc%0d got %h exp %h", i, iq.pc_iq, 32'(npop * 4)); end
      checks++; if (iq.count_iq !== m_count()) begin errors++; $display("FAIL drain_count cyc%0d got %0d exp %0d", i, iq.count_iq, m_count()); end
      npop++;
      cyc(0, 0, 1, 1, next_pc, 32'h2000 + next_pc, 1);
      if (m_pushed) next_pc += 4;
    end
  endtask

  task automatic test_back_to_back();
    cyc(1, 0, 0, 0, 0, 0, 0);
    cyc(0, 0, 1, 1, 32'h200, 32'h3200, 0);
    cyc(0, 0, 1, 1, 32'h204, 32'h3204, 0);
    for (int k = 0; k < 10; k++) begin
      checks++; if (iq.count_iq !== 3'd2) begin errors++; $display("FAIL b2b_count cyc%0d got %0d exp 2", k, iq.count_iq); end
      checks++; if (iq.pc_iq !== 32'h200 + 32'(4 * k)) begin errors++; $display("FAIL b2b_order cyc%0d got %h exp %h", k, iq.pc_iq, 32'h200 + 32'(4 * k)); end
      cyc(0, 0, 1, 1, 32'h208 + 32'(4 * k), 32'h3208 + 32'(4 * k), 1);
    end
  endtask

  task automatic test_flush_full();
    cyc(1, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 4; i++) cyc(0, 0, 1, 1, 32'h80 + 32'(4 * i), 32'h4000 + 32'(i), 0);
    checks++; if (iq.count_iq !== 3'd4) begin errors++; $display("FAIL flush_pre_count got %0d exp 4", iq.count_iq); end
    cyc(0, 1, 1, 1, 32'hF0, 32'hF0F0, 1);
    checks++; if (iq.valid_iq !== 1'b0) begin errors++; $display("FAIL flush_valid got %b exp 0", iq.valid_iq); end
    checks++; if (iq.count_iq !== 3'd0) begin errors++; $display("FAIL flush_count got %0d exp 0", iq.count_iq); end
    checks++; if (iq.allow_in_iq !== 1'b1) begin errors++; $display("FAIL flush_allow got %b exp 1", iq.allow_in_iq); end
    checks++; if (iq.instruction_iq !== NOP) begin errors++; $display("FAIL flush_inst got %h exp %h", iq.instruction_iq, NOP); end
    cyc(0, 0, 1, 1, 32'h100, 32'h00100113, 0);
    checks++; if (iq.valid_iq !== 1'b1 || iq.pc_iq !== 32'h100) begin errors++; $display("FAIL flush_repush got v=%b pc=%h exp v=1 pc=100", iq.valid_iq, iq.pc_iq); end
    checks++; if (iq.instruction_iq !== 32'h00100113) begin errors++; $display("FAIL flush_repush_inst got %h exp 00100113", iq.instruction_iq); end
  endtask

  task automatic test_reset_mid();
    cyc(1, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 3; i++) cyc(0, 0, 1, 1, 32'h300 + 32'(4 * i), 32'h5000 + 32'(i), 0);
    checks++; if (iq.count_iq !== 3'd3) begin errors++; $display("FAIL rstmid_pre_count got %0d exp 3", iq.count_iq); end
    cyc(1, 0, 1, 1, 32'h3F0, 32'h5FFF, 1);
    checks++; if (iq.count_iq !== 3'd0) begin errors++; $display("FAIL rstmid_count got %0d exp 0", iq.count_iq); end
    checks++; if (iq.valid_iq !== 1'b0) begin errors++; $display("FAIL rstmid_valid got %b exp 0", iq.valid_iq); end
    for (int i = 0; i < 4; i++) begin
      cyc(0, 0, 0, 0, 0, 0, 1);
      checks++; if (iq.valid_iq !== 1'b0 || iq.pc_iq !== 32'h0) begin errors++; $display("FAIL rstmid_stale cyc%0d v=%b pc=%h exp v=0 pc=0", i, iq.valid_iq, iq.pc_iq); end
    end
  endtask

  task automatic test_random();
    for (int n = 0; n < 400; n++) begin
      cyc(($urandom % 64) == 0, ($urandom % 16) == 0, ($urandom % 4) != 0,
          ($urandom % 4) != 0, $urandom, $urandom, ($urandom % 2) == 0);
      checks++;
      if (iq.valid_iq !== m_valid() || iq.ready_go_iq !== m_valid() ||
          iq.allow_in_iq !== m_allow() || iq.count_iq !== m_count() ||
          iq.pc_iq !== m_pc() || iq.instruction_iq !== m_inst()) begin
        errors++;
        $display("FAIL random cyc%0d got v=%b rg=%b a=%b c=%0d pc=%h i=%h exp v=%b a=%b c=%0d pc=%h i=%h",
                 n, iq.valid_iq, iq.ready_go_iq, iq.allow_in_iq, iq.count_iq, iq.pc_iq, iq.instruction_iq,
                 m_valid(), m_allow(), m_count(), m_pc(), m_inst());
      end
    end
  endtask

  initial begin
    iq.flush = 1'b0; iq.valid_if = 1'b0; iq.ready_go_if = 1'b0;
    iq.pc_if = '0; iq.instruction_if = '0; iq.allow_in_id = 1'b0;
    test_reset();
    test_fill();
    test_drain_wrap();
    test_back_to_back();
    test_flush_full();
    test_reset_mid();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
